// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter and read gate for an 8-entry FIFO.
// Tracks occupancy so the FIFO never sees a write when full or a read when empty.
module fifo_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  input  logic              rd_req,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [CNT_W-1:0]  occ,
  output logic [1:0]        state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rd_en;
  logic [CNT_W-1:0]  r_occ;
  logic [1:0]        r_state;
  logic              r_rr;

  logic              w_can_wr;
  logic              w_can_rd;
  logic              w_g0;
  logic              w_g1;
  logic              w_wi;
  logic [CNT_W-1:0]  w_occ_nxt;
  logic [1:0]        w_state_nxt;

  // Issue decisions, grant selection and next occupancy/state
  always_comb begin
    w_can_wr    = (r_occ < FULL_CNT);
    w_can_rd    = rd_req && (r_occ != '0);
    w_g0        = w_can_wr && req0 && (!req1 || !r_rr);
    w_g1        = w_can_wr && req1 && (!req0 ||  r_rr);
    w_wi        = w_g0 || w_g1;
    w_occ_nxt   = r_occ;
    if (w_wi && !w_can_rd)
      w_occ_nxt = r_occ + 1'b1;
    else if (!w_wi && w_can_rd)
      w_occ_nxt = r_occ - 1'b1;
    w_state_nxt = ST_BUSY;
    if (w_occ_nxt == '0)
      w_state_nxt = ST_IDLE;
    else if (w_occ_nxt == FULL_CNT)
      w_state_nxt = ST_FULL;
  end

  // Register all outputs; rr pointer moves to the client not granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_occ     <= '0;
      r_state   <= ST_IDLE;
      r_rr      <= 1'b0;
    end else begin
      r_gnt0  <= w_g0;
      r_gnt1  <= w_g1;
      r_wr_en <= w_wi;
      r_rd_en <= w_can_rd;
      r_occ   <= w_occ_nxt;
      r_state <= w_state_nxt;
      if (w_g0) begin
        r_wr_data <= din0;
        r_rr      <= 1'b1;
      end else if (w_g1) begin
        r_wr_data <= din1;
        r_rr      <= 1'b0;
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign rd_en   = r_rd_en;
  assign occ     = r_occ;
  assign state   = r_state;

endmodule
